queen_board_encoder: RTL and testbench

QUEEN_BOARD_ENCODER -- requirements
Module: queen_board_encoder

---
 rtl/queen_board_encoder.sv | 151 +++++++++++++++
 tb/tb_queen_board_encoder.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/queen_board_encoder.sv
// queen_board_encoder
//
// Holds an 8x8 queen board as one optional queen per row (a 3-bit column plus
// an occupied flag) and streams the board as eight one-hot row vectors on
// request.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   wr_valid/wr_ready write handshake; wr_row selects the row, wr_clear=1
//                     empties it, wr_clear=0 places a queen at wr_col
//   dump_start        starts an 8-beat dump (ignored while a dump runs)
//   busy              high for the whole dump
//   out_valid         beat qualifier for out_row_idx / out_onehot / out_last
//   out_onehot        [0:7], bit index = column, all zeros = empty row
//   placed_count      number of occupied rows, 0..8
//   dbg_state         current FSM state (0 = IDLE, 1 = DUMP)
//
// Handshake: a write transfers on a rising clk edge where wr_valid and
// wr_ready are both 1. wr_ready depends on FSM state only, so the source
// may hold wr_valid across a dump and the write lands on the first IDLE
// edge. The out_* beat stream has no back-pressure: one beat per cycle.
module queen_board_encoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_row,
    input  logic [2:0] wr_col,
    input  logic       wr_clear,
    input  logic       dump_start,
    output logic       busy,
    output logic       out_valid,
    output logic [2:0] out_row_idx,
    output logic [0:7] out_onehot,
    output logic       out_last,
    output logic [3:0] placed_count,
    output logic       dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        DUMP = 1'b1
    } state_t;

    state_t     state;
    logic [2:0] ptr;          // row currently presented on the beat outputs

    logic [2:0] col_q [8];
    logic [7:0] occ_q;

    // Board contents as they will be after this edge's write (if any).
    logic [2:0] col_d [8];
    logic [7:0] occ_d;
    logic [3:0] cnt_d;

    logic       wr_accept;
    logic [2:0] beat_row;
    logic [0:7] beat_onehot;

    assign wr_ready  = (state == IDLE);
    assign busy      = (state == DUMP);
    assign dbg_state = state;
    assign wr_accept = wr_valid && (state == IDLE);

    always_comb begin
        occ_d = occ_q;
        col_d = col_q;
        cnt_d = placed_count;
        if (wr_accept) begin
            if (wr_clear) begin
                if (occ_q[wr_row] && (placed_count != 4'd0)) begin
                    occ_d[wr_row] = 1'b0;
                    cnt_d         = placed_count - 4'd1;
                end
            end else begin
                col_d[wr_row] = wr_col;
                if (!occ_q[wr_row] && (placed_count != 4'd8)) begin
                    occ_d[wr_row] = 1'b1;
                    cnt_d         = placed_count + 4'd1;
                end
            end
        end
    end

    // Row of the beat that will be registered on this edge. Beat data is
    // taken from the post-write board so a write accepted together with
    // dump_start is already visible in the first beat.
    assign beat_row = (state == IDLE) ? 3'd0 : (ptr + 3'd1);

    always_comb begin
        beat_onehot = '0;
        if (occ_d[beat_row]) begin
            beat_onehot[col_d[beat_row]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= 3'd0;
            occ_q        <= '0;
            for (int i = 0; i < 8; i++) begin
                col_q[i] <= 3'd0;
            end
            placed_count <= 4'd0;
            out_valid    <= 1'b0;
            out_row_idx  <= 3'd0;
            out_onehot   <= '0;
            out_last     <= 1'b0;
        end else begin
            occ_q        <= occ_d;
            for (int i = 0; i < 8; i++) begin
                col_q[i] <= col_d[i];
            end
            placed_count <= cnt_d;

            case (state)
                IDLE: begin
                    if (dump_start) begin
                        state       <= DUMP;
                        ptr         <= 3'd0;
                        out_valid   <= 1'b1;
                        out_row_idx <= 3'd0;
                        out_onehot  <= beat_onehot;
                        out_last    <= 1'b0;
                    end
                end
                DUMP: begin
                    if (ptr == 3'd7) begin
                        state       <= IDLE;
                        ptr         <= 3'd0;
                        out_valid   <= 1'b0;
                        out_row_idx <= 3'd0;
                        out_onehot  <= '0;
                        out_last    <= 1'b0;
                    end else begin
                        ptr         <= ptr + 3'd1;
                        out_valid   <= 1'b1;
                        out_row_idx <= ptr + 3'd1;
                        out_onehot  <= beat_onehot;
                        out_last    <= (ptr == 3'd6);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_queen_board_encoder.sv
module tb_queen_board_encoder;

    logic       clk;
    logic       rst_n;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_row;
    logic [2:0] wr_col;
    logic       wr_clear;
    logic       dump_start;
    logic       busy;
    logic       out_valid;
    logic [2:0] out_row_idx;
    logic [0:7] out_onehot;
    logic       out_last;
    logic [3:0] placed_count;
    logic       dbg_state;

    int vectors;
    int miscompares;

    // Captured dump: samples 0..7 are the beats, sample 8 is the cycle after.
    logic       cap_valid [9];
    logic [2:0] cap_idx   [9];
    logic [0:7] cap_oh    [9];
    logic       cap_last  [9];
    logic       cap_busy  [9];
    logic       cap_ready [9];

    logic [0:7] exp_oh [8];

    queen_board_encoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_row       (wr_row),
        .wr_col       (wr_col),
        .wr_clear     (wr_clear),
        .dump_start   (dump_start),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_row_idx  (out_row_idx),
        .out_onehot   (out_onehot),
        .out_last     (out_last),
        .placed_count (placed_count),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_write(input logic [2:0] row, input logic [2:0] col, input logic clr);
        wr_valid = 1'b1;
        wr_row   = row;
        wr_col   = col;
        wr_clear = clr;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic capture_dump();
        dump_start = 1'b1;
        @(posedge clk);
        #1;
        dump_start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            cap_valid[k] = out_valid;
            cap_idx[k]   = out_row_idx;
            cap_oh[k]    = out_onehot;
            cap_last[k]  = out_last;
            cap_busy[k]  = busy;
            cap_ready[k] = wr_ready;
            if (k < 8) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b1 ||
            placed_count !== 4'd0 || out_onehot !== 8'b0 || out_last !== 1'b0 ||
            out_row_idx !== 3'd0 || dbg_state !== 1'b0) begin
            $display("FAIL reset_state: valid=%b busy=%b ready=%b cnt=%0d oh=%b last=%b idx=%0d st=%b, need 0 0 1 0 00000000 0 0 0",
                     out_valid, busy, wr_ready, placed_count, out_onehot, out_last, out_row_idx, dbg_state);
            miscompares++;
        end
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_empty_dump();
        capture_dump();
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (cap_valid[k] !== 1'b1 || cap_idx[k] !== k[2:0] || cap_oh[k] !== 8'b0 ||
                cap_last[k] !== (k == 7) || cap_busy[k] !== 1'b1 || cap_ready[k] !== 1'b0) begin
                $display("FAIL empty_dump beat %0d: valid=%b idx=%0d oh=%b last=%b busy=%b ready=%b",
                         k, cap_valid[k], cap_idx[k], cap_oh[k], cap_last[k], cap_busy[k], cap_ready[k]);
                miscompares++;
            end
        end
        vectors++;
        if (cap_valid[8] !== 1'b0 || cap_busy[8] !== 1'b0 || cap_ready[8] !== 1'b1 ||
            cap_oh[8] !== 8'b0 || cap_idx[8] !== 3'd0 || placed_count !== 4'd0) begin
            $display("FAIL empty_dump_end: valid=%b busy=%b ready=%b oh=%b idx=%0d cnt=%0d, need 0 0 1 0 0 0",
                     cap_valid[8], cap_busy[8], cap_ready[8], cap_oh[8], cap_idx[8], placed_count);
            miscompares++;
        end
    endtask

    task automatic test_full_board();
        logic [2:0] cols [8];
        cols = '{3'd0, 3'd4, 3'd7, 3'd5, 3'd2, 3'd6, 3'd1, 3'd3};
        exp_oh = '{8'b10000000, 8'b00001000, 8'b00000001, 8'b00000100,
                   8'b00100000, 8'b00000010, 8'b01000000, 8'b00010000};
        for (int r = 0; r < 8; r++) begin
            do_write(r[2:0], cols[r], 1'b0);
            vectors++;
            if (placed_count !== 4'(r + 1)) begin
                $display("FAIL full_count after row %0d: got %0d need %0d", r, placed_count, r + 1);
                miscompares++;
            end
        end
        for (int pass = 0; pass < 2; pass++) begin
            capture_dump();
            for (int k = 0; k < 8; k++) begin
                vectors++;
                if (cap_valid[k] !== 1'b1 || cap_idx[k] !== k[2:0] || cap_oh[k] !== exp_oh[k] ||
                    cap_last[k] !== (k == 7)) begin
                    $display("FAIL full_dump pass %0d beat %0d: valid=%b idx=%0d oh=%b last=%b, need oh=%b",
                             pass, k, cap_valid[k], cap_idx[k], cap_oh[k], cap_last[k], exp_oh[k]);
                    miscompares++;
                end
            end
            vectors++;
            if (placed_count !== 4'd8 || cap_valid[8] !== 1'b0) begin
                $display("FAIL full_dump_end pass %0d: cnt=%0d valid=%b, need 8 0", pass, placed_count, cap_valid[8]);
                miscompares++;
            end
        end
    endtask

    task automatic test_overwrite_clear();
        logic [3:0] exp_cnt [4];
        exp_cnt = '{4'd1, 4'd1, 4'd0, 4'd0};
        apply_reset();
        do_write(3'd3, 3'd5, 1'b0);
        vectors++;
        if (placed_count !== exp_cnt[0]) begin
            $display("FAIL ovr_place: cnt=%0d need %0d", placed_count, exp_cnt[0]);
            miscompares++;
        end
        do_write(3'd3, 3'd1, 1'b0);
        vectors++;
        if (placed_count !== exp_cnt[1]) begin
            $display("FAIL ovr_overwrite: cnt=%0d need %0d", placed_count, exp_cnt[1]);
            miscompares++;
        end
        capture_dump();
        vectors++;
        if (cap_oh[3] !== 8'b01000000) begin
            $display("FAIL ovr_dump_row3: got %b need 01000000", cap_oh[3]);
            miscompares++;
        end
        do_write(3'd3, 3'd7, 1'b1);
        vectors++;
        if (placed_count !== exp_cnt[2]) begin
            $display("FAIL ovr_clear: cnt=%0d need %0d", placed_count, exp_cnt[2]);
            miscompares++;
        end
        do_write(3'd3, 3'd2, 1'b1);
        vectors++;
        if (placed_count !== exp_cnt[3]) begin
            $display("FAIL ovr_clear_empty: cnt=%0d need %0d", placed_count, exp_cnt[3]);
            miscompares++;
        end
        capture_dump();
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (cap_oh[k] !== 8'b0) begin
                $display("FAIL ovr_dump_after_clear row %0d: got %b need 00000000", k, cap_oh[k]);
                miscompares++;
            end
        end
    endtask

    task automatic test_write_with_dump();
        // Board empty, count 0 on entry.
        wr_valid   = 1'b1;
        wr_row     = 3'd2;
        wr_col     = 3'd6;
        wr_clear   = 1'b0;
        dump_start = 1'b1;
        @(posedge clk);
        #1;
        dump_start = 1'b0;
        // New request raised during the dump and held until accepted.
        wr_row = 3'd5;
        wr_col = 3'd0;
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (wr_ready !== 1'b0 || out_valid !== 1'b1 || out_row_idx !== k[2:0] ||
                out_onehot !== ((k == 2) ? 8'b00000010 : 8'b00000000)) begin
                $display("FAIL wrdump beat %0d: ready=%b valid=%b idx=%0d oh=%b", k, wr_ready, out_valid, out_row_idx, out_onehot);
                miscompares++;
            end
            @(posedge clk);
            #1;
        end
        vectors++;
        if (wr_ready !== 1'b1 || out_valid !== 1'b0 || placed_count !== 4'd1) begin
            $display("FAIL wrdump_idle: ready=%b valid=%b cnt=%0d, need 1 0 1", wr_ready, out_valid, placed_count);
            miscompares++;
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        vectors++;
        if (placed_count !== 4'd2) begin
            $display("FAIL wrdump_held_accept: cnt=%0d need 2", placed_count);
            miscompares++;
        end
        // Row-0 write together with dump_start must show in the first beat.
        wr_valid   = 1'b1;
        wr_row     = 3'd0;
        wr_col     = 3'd7;
        wr_clear   = 1'b0;
        capture_dump();
        wr_valid = 1'b0;
        vectors++;
        if (cap_oh[0] !== 8'b00000001 || cap_oh[2] !== 8'b00000010 || cap_oh[5] !== 8'b10000000 ||
            placed_count !== 4'd3) begin
            $display("FAIL wrdump_row0: oh0=%b oh2=%b oh5=%b cnt=%0d, need 00000001 00000010 10000000 3",
                     cap_oh[0], cap_oh[2], cap_oh[5], placed_count);
            miscompares++;
        end
    endtask

    task automatic test_restart_ignored();
        int beats;
        beats = 0;
        dump_start = 1'b1;
        @(posedge clk);
        #1;
        dump_start = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (out_valid === 1'b1) begin
                vectors++;
                if (out_row_idx !== beats[2:0]) begin
                    $display("FAIL restart_order: idx=%0d need %0d", out_row_idx, beats);
                    miscompares++;
                end
                beats++;
            end
            dump_start = (c == 4);
            @(posedge clk);
            #1;
            dump_start = 1'b0;
        end
        vectors++;
        if (beats !== 8 || busy !== 1'b0 || dbg_state !== 1'b0) begin
            $display("FAIL restart_beats: beats=%0d busy=%b st=%b, need 8 0 0", beats, busy, dbg_state);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_dump();
        int stray;
        stray = 0;
        dump_start = 1'b1;
        @(posedge clk);
        #1;
        dump_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
        end
        vectors++;
        if (out_row_idx !== 3'd5 || out_valid !== 1'b1) begin
            $display("FAIL midrst_pre: idx=%0d valid=%b need 5 1", out_row_idx, out_valid);
            miscompares++;
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_onehot !== 8'b0 || out_row_idx !== 3'd0 || out_last !== 1'b0 ||
            busy !== 1'b0 || wr_ready !== 1'b1 || placed_count !== 4'd0) begin
            $display("FAIL midrst_async: valid=%b oh=%b idx=%0d last=%b busy=%b ready=%b cnt=%0d",
                     out_valid, out_onehot, out_row_idx, out_last, busy, wr_ready, placed_count);
            miscompares++;
        end
        #10 rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) stray++;
        end
        vectors++;
        if (stray !== 0) begin
            $display("FAIL midrst_no_beats: %0d stray cycles, need 0", stray);
            miscompares++;
        end
        capture_dump();
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (cap_valid[k] !== 1'b1 || cap_idx[k] !== k[2:0] || cap_oh[k] !== 8'b0) begin
                $display("FAIL midrst_redump beat %0d: valid=%b idx=%0d oh=%b", k, cap_valid[k], cap_idx[k], cap_oh[k]);
                miscompares++;
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        wr_valid    = 1'b0;
        wr_row      = 3'd0;
        wr_col      = 3'd0;
        wr_clear    = 1'b0;
        dump_start  = 1'b0;

        test_reset();
        test_empty_dump();
        test_full_board();
        test_overwrite_clear();
        test_write_with_dump();
        test_restart_ignored();
        test_reset_mid_dump();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
